// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: queues scan-code bytes and clocks 11-bit frames onto the open-drain pair.
// Latency: first clock fall CLK_DIV+1 cycles after a push once the bus has idled; frame = 22*CLK_DIV cycles.
// Backpressure: tx_ready drops when the byte FIFO is full; a push while full is dropped and sets overflow.

module ps2_tx_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_n;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_comb begin
        level_n = level;
        if (do_push && !do_pop)
            level_n = level + 1'b1;
        else if (!do_push && do_pop)
            level_n = level - 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_n;
            full  <= (level_n == FULL_LVL);
            empty <= (level_n == '0);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module ps2_device_tx #(
    parameter int CLK_DIV     = 2000,
    parameter int IDLE_CYCLES = 2500,
    parameter int FIFO_AW     = 4
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               ps2_clk_out,
    output logic               ps2_data_out,
    input  logic               ps2_clk_in,
    input  logic               ps2_data_in,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow
);
    localparam int CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW     = $clog2(IDLE_CYCLES + 1);
    // The inhibit check must wait out the synchroniser after releasing the clock;
    // a very short half-period clamps the wait to its last cycle.
    localparam int SETTLE = (CLK_DIV > 4) ? 4 : CLK_DIV - 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_SETTL = CW'(SETTLE);
    localparam logic [IW-1:0] IDLE_DONE = IW'(IDLE_CYCLES);

    typedef enum logic {WAIT_IDLE, SEND} state_t;
    typedef enum logic {PH_HIGH, PH_LOW} phase_t;

    state_t        state_q, state_n;
    phase_t        phase_q, phase_n;
    logic [3:0]    bit_q, bit_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [IW-1:0] idle_q, idle_n;
    logic          clk_n, dat_n, busy_n;
    logic [1:0]    clk_sync, dat_sync;
    logic          sclk, sdat;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    head;
    logic [10:0]   frame;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_data_in};
        end
    end
    assign sclk = clk_sync[1];
    assign sdat = dat_sync[1];

    ps2_tx_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .push     (tx_valid),
        .push_dat (tx_data),
        .pop      (fifo_pop),
        .head_dat (head),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );
    assign tx_ready = !fifo_full;
    assign frame    = {1'b1, ~^head, head, 1'b0};

    always_comb begin
        state_n  = state_q;
        phase_n  = phase_q;
        bit_n    = bit_q;
        cnt_n    = cnt_q;
        idle_n   = idle_q;
        fifo_pop = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                if (sclk && sdat) begin
                    if (idle_q != IDLE_DONE) idle_n = idle_q + 1'b1;
                end else begin
                    idle_n = '0;
                end
                if (idle_q == IDLE_DONE && sclk && sdat && !fifo_empty) begin
                    state_n = SEND;
                    phase_n = PH_HIGH;
                    bit_n   = 4'd0;
                    cnt_n   = '0;
                    idle_n  = '0;
                end
            end
            SEND: begin
                if (phase_q == PH_HIGH) begin
                    if (cnt_q >= CNT_SETTL && bit_q <= 4'd9 && !sclk) begin
                        // Host inhibit: drop the frame, keep the byte for a full resend.
                        state_n = WAIT_IDLE;
                        idle_n  = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        phase_n = PH_LOW;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_n = '0;
                    if (bit_q < 4'd10) begin
                        bit_n   = bit_q + 1'b1;
                        phase_n = PH_HIGH;
                    end else begin
                        state_n  = WAIT_IDLE;
                        idle_n   = '0;
                        fifo_pop = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: state_n = WAIT_IDLE;
        endcase

        busy_n = (state_n == SEND);
        clk_n  = !(busy_n && phase_n == PH_LOW);
        dat_n  = busy_n ? frame[bit_n] : 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= WAIT_IDLE;
            phase_q      <= PH_HIGH;
            bit_q        <= 4'd0;
            cnt_q        <= '0;
            idle_q       <= '0;
            ps2_clk_out  <= 1'b1;
            ps2_data_out <= 1'b1;
            busy         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state_q      <= state_n;
            phase_q      <= phase_n;
            bit_q        <= bit_n;
            cnt_q        <= cnt_n;
            idle_q       <= idle_n;
            ps2_clk_out  <= clk_n;
            ps2_data_out <= dat_n;
            busy         <= busy_n;
            if (tx_valid && fifo_full) overflow <= 1'b1;
        end
    end
endmodule
